// File: rtl/memctl_pkg.sv
// Shared definitions for the ROM-to-buffer streaming controller:
// FSM state encoding, default parameter values and address-width helper.
package memctl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDR_WIDTH     = 10;
  localparam int unsigned DEF_ROM_ADDR_WIDTH = 15;
  localparam int unsigned DEF_ROM_DEPTH      = 32768;
  localparam int unsigned DEF_NUM_SAMPLE     = 512;
  localparam int unsigned DEF_NUM_CH         = 2;

  // Minimum buffer address width able to hold one frame of num_ch*num_sample words.
  function automatic int unsigned addr_width_req(input int unsigned num_ch,
                                                 input int unsigned num_sample);
    int unsigned words;
    words = num_ch * num_sample;
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/memctl_addr_gen.sv
// Planar buffer address generator: converts the interleaved word order of the
// ROM into channel-major buffer addresses using counters only (no multiplier).
module memctl_addr_gen
  import memctl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_SAMPLE = DEF_NUM_SAMPLE,
  parameter int unsigned NUM_CH     = DEF_NUM_CH
) (
  input  logic                  CLOCK_I,
  input  logic                  RESETN_I,
  input  logic                  i_clear,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  localparam int unsigned CH_W = 2;

  logic [CH_W-1:0]       r_ch;
  logic [ADDR_WIDTH-1:0] r_smp;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  w_ch_wrap;

  assign w_ch_wrap = (r_ch == CH_W'(NUM_CH - 1));
  assign o_addr    = r_base + r_smp;
  assign o_last    = w_ch_wrap && (r_smp == ADDR_WIDTH'(NUM_SAMPLE - 1));

  // Channel counter, sample counter and channel base accumulator.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      r_ch   <= '0;
      r_smp  <= '0;
      r_base <= '0;
    end else if (i_clear) begin
      r_ch   <= '0;
      r_smp  <= '0;
      r_base <= '0;
    end else if (i_advance) begin
      if (w_ch_wrap) begin
        r_ch   <= '0;
        r_base <= '0;
        r_smp  <= r_smp + ADDR_WIDTH'(1);
      end else begin
        r_ch   <= r_ch + CH_W'(1);
        r_base <= r_base + ADDR_WIDTH'(NUM_SAMPLE);
      end
    end
  end

endmodule

// File: rtl/memstream_ctl.sv
// ROM-to-frame-buffer streaming controller. Copies one NUM_CH x NUM_SAMPLE
// frame per START_I, converting interleaved ROM order to planar buffer order,
// with HOLD_I back-pressure handled by replaying the pending ROM address.
// Optional feature macro: MEMCTL_LOOP_EN (wrap the ROM and keep playing).
module memstream_ctl
  import memctl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned ROM_ADDR_WIDTH = DEF_ROM_ADDR_WIDTH,
  parameter int unsigned ROM_DEPTH      = DEF_ROM_DEPTH,
  parameter int unsigned NUM_SAMPLE     = DEF_NUM_SAMPLE,
  parameter int unsigned NUM_CH         = DEF_NUM_CH
) (
  input  logic                      CLOCK_I,
  input  logic                      RESETN_I,
  input  logic                      START_I,
  input  logic                      HOLD_I,
  output logic [ROM_ADDR_WIDTH-1:0] ROM_ADDR_O,
  input  logic [DATA_WIDTH-1:0]     ROM_DATA_I,
  output logic [ADDR_WIDTH-1:0]     ADDRESS_O,
  output logic [DATA_WIDTH-1:0]     DATA_O,
  output logic                      WE_O,
  output logic                      EN_O,
  output logic                      DONE_O,
  output logic                      EOF_O
);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ROM_ADDR_WIDTH-1:0] r_phys;
  logic [ROM_ADDR_WIDTH-1:0] w_phys_inc;
  logic [ROM_ADDR_WIDTH-1:0] w_rom_addr;
  logic                      r_eof;
  logic                      w_we_q;
  logic                      w_write;
  logic                      w_last_word;
  logic                      w_rom_end;
  logic                      w_frame_wrap;
  logic                      w_start_ok;
  logic [ADDR_WIDTH-1:0]     w_addr;

  memctl_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SAMPLE (NUM_SAMPLE),
    .NUM_CH     (NUM_CH)
  ) u_addr_gen (
    .CLOCK_I   (CLOCK_I),
    .RESETN_I  (RESETN_I),
    .i_clear   (r_state == IDLE),
    .i_advance (w_write),
    .o_addr    (w_addr),
    .o_last    (w_last_word)
  );

  assign w_rom_end    = (r_phys == ROM_ADDR_WIDTH'(ROM_DEPTH - 1));
  assign w_phys_inc   = w_rom_end ? '0 : r_phys + ROM_ADDR_WIDTH'(1);
  assign w_write      = w_we_q & ~HOLD_I;
  assign w_frame_wrap = w_write & w_last_word & w_rom_end;

`ifdef MEMCTL_LOOP_EN
  assign w_start_ok = 1'b1;
`else
  assign w_start_ok = ~r_eof;
`endif

  assign ROM_ADDR_O = w_rom_addr;
  assign ADDRESS_O  = w_addr;
  assign DATA_O     = ROM_DATA_I;
  assign WE_O       = w_write;
  assign DONE_O     = (r_state == IDLE);
  assign EN_O       = ~DONE_O;
  assign EOF_O      = r_eof;

  // State register.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state, write qualifier and ROM address. On a held STREAM cycle the
  // pending address stays on the ROM so the same word returns next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_we_q      = 1'b0;
    w_rom_addr  = r_phys;
    case (r_state)
      IDLE:    if (START_I && w_start_ok) w_state_nxt = PRIME;
      PRIME:   w_state_nxt = STREAM;
      STREAM: begin
        w_we_q = 1'b1;
        if (!HOLD_I) begin
          w_rom_addr = w_phys_inc;
          if (w_last_word) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Physical ROM pointer; persists across frames, advances once per write.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I)    r_phys <= '0;
    else if (w_write) r_phys <= w_phys_inc;
  end

  // End-of-ROM flag: one-cycle pulse when looping, sticky otherwise.
  always_ff @(posedge CLOCK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      r_eof <= 1'b0;
    end else begin
`ifdef MEMCTL_LOOP_EN
      r_eof <= w_frame_wrap;
`else
      if (w_frame_wrap) r_eof <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_memstream_ctl.sv
// Self-checking bench for memstream_ctl: a 2ch x 4-sample instance on a
// 16-word ROM and a 1ch x 512-sample instance, each fed by a ROM with ROM[i]=i.
module tb_memstream_ctl;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RAW = 4;
  localparam int RD = 16;
  localparam int NS = 4;
  localparam int NC = 2;
  localparam int N = NC * NS;

  localparam int AW1 = 9;
  localparam int RAW1 = 10;
  localparam int RD1 = 1024;
  localparam int NS1 = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start, hold, start1;

  logic [RAW-1:0] rom_addr;
  logic [DW-1:0]  rom_data;
  logic [AW-1:0]  addr;
  logic [DW-1:0]  data;
  logic           we, en, done, eof;

  logic [RAW1-1:0] rom_addr1;
  logic [DW-1:0]   rom_data1;
  logic [AW1-1:0]  addr1;
  logic [DW-1:0]   data1;
  logic            we1, en1, done1, eof1;

  memstream_ctl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROM_ADDR_WIDTH(RAW),
    .ROM_DEPTH(RD), .NUM_SAMPLE(NS), .NUM_CH(NC)
  ) dut (
    .CLOCK_I(clk), .RESETN_I(rstn), .START_I(start), .HOLD_I(hold),
    .ROM_ADDR_O(rom_addr), .ROM_DATA_I(rom_data), .ADDRESS_O(addr),
    .DATA_O(data), .WE_O(we), .EN_O(en), .DONE_O(done), .EOF_O(eof)
  );

  memstream_ctl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW1), .ROM_ADDR_WIDTH(RAW1),
    .ROM_DEPTH(RD1), .NUM_SAMPLE(NS1), .NUM_CH(1)
  ) dut1 (
    .CLOCK_I(clk), .RESETN_I(rstn), .START_I(start1), .HOLD_I(1'b0),
    .ROM_ADDR_O(rom_addr1), .ROM_DATA_I(rom_data1), .ADDRESS_O(addr1),
    .DATA_O(data1), .WE_O(we1), .EN_O(en1), .DONE_O(done1), .EOF_O(eof1)
  );

  // Synchronous-read ROMs, one cycle latency, ROM[i] = i.
  always @(posedge clk) begin
    rom_data  <= DW'(rom_addr);
    rom_data1 <= DW'(rom_addr1);
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cnt1 = 0;
  int first_we_cyc = -1;
  bit first_pending = 1'b0;
  int m_phys = 0;

  typedef struct { int a; int d; } exp_t;
  exp_t q[$];
  exp_t q1[$];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every buffer write pops the oldest expected (addr, data).
  always @(negedge clk) begin
    exp_t e;
    if (rstn && we) begin
      wr_cnt++;
      if (first_pending) begin
        first_we_cyc  = cyc;
        first_pending = 1'b0;
      end
      if (q.size() == 0) check_val("unexpected_we", 1, 0);
      else begin
        e = q.pop_front();
        check_val("wr_addr", 64'(addr), 64'(e.a));
        check_val("wr_data", 64'(data), 64'(e.d));
      end
    end
    if (rstn && we1) begin
      wr_cnt1++;
      if (q1.size() == 0) check_val("unexpected_we1", 1, 0);
      else begin
        e = q1.pop_front();
        check_val("wr1_addr", 64'(addr1), 64'(e.a));
        check_val("wr1_data", 64'(data1), 64'(e.d));
      end
    end
  end

  // Expected planar writes for one frame starting at the model's ROM pointer.
  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.a = (k % NC) * NS + k / NC;
      e.d = (m_phys + k) % RD;
      q.push_back(e);
    end
    m_phys = (m_phys + N) % RD;
  endtask

  // Called #1 after a posedge. Pulses START, optionally holds, counts DONE-low cycles.
  task automatic do_frame(input int hold_at, input int hold_len,
                          output int low, output int t0, output logic eof_rise);
    push_frame();
    first_pending = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    check_val("done_fall", 64'(done), 0);
    low = 0;
    while (done == 1'b0 && low < 200) begin
      hold = (low >= hold_at) && (low < hold_at + hold_len);
      low++;
      @(posedge clk); #1;
    end
    hold = 1'b0;
    eof_rise = eof;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_done"}, 64'(done), 1);
    check_val({tag, "_en"}, 64'(en), 0);
    check_val({tag, "_we"}, 64'(we), 0);
    check_val({tag, "_addr"}, 64'(addr), 0);
    check_val({tag, "_romaddr"}, 64'(rom_addr), 0);
    check_val({tag, "_eof"}, 64'(eof), 0);
  endtask

  initial begin
    int low, t0, base, n;
    logic eof_rise;
    exp_t e;

    rstn = 1'b0; start = 1'b0; hold = 1'b0; start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Plain frame: ROM[0..7], first write at T+2, DONE low N+1 cycles.
    do_frame(1000, 0, low, t0, eof_rise);
    check_val("f1_done_low", 64'(low), 64'(N + 1));
    // monitor samples in the cycle before the write edge, so T+1 means a write at T+2
    check_val("f1_first_we", 64'(first_we_cyc), 64'(t0 + 1));
    check_val("f1_eof", 64'(eof_rise), 0);
    check_val("f1_sb_empty", 64'(q.size()), 0);

    // Held frame: ROM[8..15], 3 hold cycles mid-frame, ends at ROM end.
    base = wr_cnt;
    do_frame(3, 3, low, t0, eof_rise);
    check_val("hold_done_low", 64'(low), 64'(N + 4));
    check_val("hold_we_count", 64'(wr_cnt - base), 64'(N));
    check_val("hold_sb_empty", 64'(q.size()), 0);
    check_val("eof_at_done_rise", 64'(eof_rise), 1);
    @(posedge clk); #1;
`ifdef MEMCTL_LOOP_EN
    check_val("eof_pulse_end", 64'(eof), 0);
    do_frame(1000, 0, low, t0, eof_rise);
    check_val("loop_f3_low", 64'(low), 64'(N + 1));
    check_val("loop_f3_eof", 64'(eof_rise), 0);
    check_val("loop_sb_empty", 64'(q.size()), 0);
`else
    check_val("eof_sticky", 64'(eof), 1);
    base = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_val("eof_no_we", 64'(wr_cnt - base), 0);
    check_val("eof_done_stays", 64'(done), 1);
    check_val("eof_still_set", 64'(eof), 1);
`endif

    // Back-to-back frames with START held: one IDLE cycle between frames.
    rstn = 1'b0; q.delete(); m_phys = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    push_frame();
    push_frame();
    base = wr_cnt;
    start = 1'b1;
    n = 0;
    while (wr_cnt < base + 2 * N && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check_val("b2b_edges", 64'(n), 64'(2 * N + 4));
    check_val("b2b_done", 64'(done), 1);
    check_val("b2b_sb_empty", 64'(q.size()), 0);

    // Reset in the cycle of the 5th write, then a clean restart from ROM[0].
    rstn = 1'b0; q.delete(); m_phys = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    push_frame();
    base = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    check_val("midreset_writes", 64'(wr_cnt - base), 4);
    q.delete(); m_phys = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_frame(1000, 0, low, t0, eof_rise);
    check_val("restart_low", 64'(low), 64'(N + 1));
    check_val("restart_sb_empty", 64'(q.size()), 0);

    // Single channel, 512 samples: sequential addresses and ROM reads.
    for (int i = 0; i < NS1; i++) begin
      e.a = i; e.d = i;
      q1.push_back(e);
    end
    base = wr_cnt1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check_val("ch1_prime_romaddr", 64'(rom_addr1), 0);
    n = 0;
    while (done1 == 1'b0 && n < 700) begin
      n++;
      @(posedge clk); #1;
    end
    check_val("ch1_done_low", 64'(n), 64'(NS1 + 1));
    check_val("ch1_writes", 64'(wr_cnt1 - base), 64'(NS1));
    check_val("ch1_sb_empty", 64'(q1.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
